// File: rtl/chunked_adder_pkg.sv
// Shared definitions for chunked_adder: FSM state encoding and the
// chunk-index width helper.
package chunked_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Index counter width: clog2(N/W), never narrower than one bit.
  function automatic int idx_width(input int n, input int w);
    int k;
    k = n / w;
    return (k <= 2) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/chunked_adder_chunk_add.sv
// chunk_add: combinational W-bit ripple-carry adder that also exposes the
// carry into its top bit so the parent can form signed overflow.
module chunk_add #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]     = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/chunked_adder.sv
// chunked_adder: N-bit adder processed W bits per clock with a registered
// inter-chunk carry. Define CHUNKED_ADDER_SUB_EN to add the sub port (a - b).
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
`ifdef CHUNKED_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int K  = N / W;
  localparam int IW = idx_width(N, W);
  localparam logic [IW-1:0] LAST_IDX   = IW'(K - 1);
  localparam logic [N-1:0]  CHUNK_MASK = {N{1'b1}} >> (N - W);

  state_e        state_q, state_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;

  logic [31:0]   base;
  logic [W-1:0]  a_chunk, b_chunk, s_chunk;
  logic          co_chunk, cmsb_chunk;
  logic          b_inv, c_init;

  // Subtraction is folded in at capture time: store ~b and force carry-in to 1.
`ifdef CHUNKED_ADDER_SUB_EN
  assign b_inv  = sub;
  assign c_init = sub | cin;
`else
  assign b_inv  = 1'b0;
  assign c_init = cin;
`endif

  assign base    = 32'(idx_q) * 32'(W);
  assign a_chunk = W'(a_q >> base);
  assign b_chunk = W'(b_q >> base);

  chunk_add #(.W(W)) u_chunk_add (
    .x     (a_chunk),
    .y     (b_chunk),
    .ci    (carry_q),
    .s     (s_chunk),
    .co    (co_chunk),
    .c_msb (cmsb_chunk)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_inv ? ~b : b;
          carry_d = c_init;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~(CHUNK_MASK << base)) | (N'(s_chunk) << base);
        carry_d = co_chunk;
        idx_d   = idx_q + 1'b1;
        // The top chunk's internal carries give cout and the MSB carry-in.
        if (idx_q == LAST_IDX) begin
          cout_d  = co_chunk;
          ovf_d   = cmsb_chunk ^ co_chunk;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
